// File: rtl/counter_down_if.sv
// Control/status bundle for counter_down: the controller drives the requests,
// the counter returns its registered count, busy and done.
interface counter_down_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause, stop,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, pause, stop,
    output count, busy, done
  );
endinterface

// File: rtl/counter_down.sv
// Programmable down-counter / countdown timer with pause, abort and a one-cycle done pulse.
// Define COUNTER_DOWN_RELOAD_EN for auto-reload (periodic done) instead of one-shot.
module counter_down #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  counter_down_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] eff_count;
`ifdef COUNTER_DOWN_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
`ifdef COUNTER_DOWN_RELOAD_EN
    reload_d  = reload_q;
`endif
    eff_count = bus.load ? bus.load_val : count_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.load) begin
          count_d  = bus.load_val;
`ifdef COUNTER_DOWN_RELOAD_EN
          reload_d = bus.load_val;
`endif
        end
        if (bus.start) begin
          state_d = (eff_count != '0) ? RUN : DONE;
        end
      end

      // Leaving HOLD with pause low is itself a decrement step, so each
      // HOLD cycle adds exactly one cycle of latency.
      RUN, HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.pause) begin
          state_d = HOLD;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
          state_d = RUN;
        end else begin
`ifdef COUNTER_DOWN_RELOAD_EN
          if (count_q == ONE) begin
            count_d = reload_q;
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
`else
          count_d = '0;
          state_d = DONE;
`endif
        end
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == HOLD);
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTER_DOWN_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef COUNTER_DOWN_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_down.sv
// Self-checking bench for counter_down: each driven cycle pushes its expected
// count/busy/done; a monitor pops and compares one entry after every rising edge.
module tb_counter_down;

  localparam int WIDTH = 8;

  typedef struct {
    string tag;
    int    count;
    bit    busy;
    bit    done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  counter_down_if #(.WIDTH(WIDTH)) bus ();

  counter_down #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc(input string tag, input bit ld, input int lv, input bit st,
                     input bit pa, input bit sp, input int ec, input bit eb, input bit ed);
    exp_t e;
    @(negedge clk);
    bus.load     = ld;
    bus.load_val = WIDTH'(lv);
    bus.start    = st;
    bus.pause    = pa;
    bus.stop     = sp;
    e.tag   = tag;
    e.count = ec;
    e.busy  = eb;
    e.done  = ed;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input int ec, input bit eb, input bit ed);
    cyc(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0, ec, eb, ed);
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".count"}, 32'(bus.count), 32'(e.count));
      check({e.tag, ".busy"},  32'(bus.busy),  32'(e.busy));
      check({e.tag, ".done"},  32'(bus.done),  32'(e.done));
    end
  end

  initial begin
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.stop     = 1'b0;
    #3;
    check("reset.count", 32'(bus.count), 0);
    check("reset.busy",  32'(bus.busy),  0);
    check("reset.done",  32'(bus.done),  0);
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-count clears outputs at once and leaves no done behind.
    cyc("rstmid", 1'b1, 5, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) idle("rstmid", 5 - j, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rstmid.async.count", 32'(bus.count), 0);
    check("rstmid.async.busy",  32'(bus.busy),  0);
    check("rstmid.async.done",  32'(bus.done),  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 5; j++) idle("rstmid.after", 0, 1'b0, 1'b0);

`ifndef COUNTER_DOWN_RELOAD_EN
    // One-shot of 5 with load and start together.
    cyc("oneshot", 1'b1, 5, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    for (int j = 1; j <= 5; j++) idle("oneshot", 5 - j, j < 5, j == 5);
    idle("oneshot.end", 0, 1'b0, 1'b0);

    // Start 10, pause for 3 cycles at 7: done 13 cycles after start.
    cyc("pause", 1'b1, 10, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) idle("pause", 10 - j, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) cyc("pause.hold", 1'b0, 0, 1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b0);
    for (int j = 1; j <= 7; j++) idle("pause.resume", 7 - j, j < 7, j == 7);

    // Load/start during RUN are dropped; a load+start in the DONE cycle restarts.
    cyc("ignore", 1'b1, 6, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      if (j == 2) cyc("ignore.req", 1'b1, 99, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0);
      else        idle("ignore", 6 - j, j < 6, j == 6);
    end
    cyc("restart", 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle("restart", 1, 1'b1, 1'b0);
    idle("restart", 0, 1'b0, 1'b1);
    idle("restart.end", 0, 1'b0, 1'b0);

    // Full-scale count: 255 down to 0 with no wrap.
    cyc("max", 1'b1, 255, 1'b1, 1'b0, 1'b0, 255, 1'b1, 1'b0);
    for (int j = 1; j <= 255; j++) idle("max", 255 - j, j < 255, j == 255);
    idle("max.end", 0, 1'b0, 1'b0);
`else
    // Auto-reload of 3: 3,2,1,3,2,1... with done on each 1->3 step.
    cyc("reload3", 1'b1, 3, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) idle("reload3", 3 - (i % 3), 1'b1, (i % 3) == 0);
    cyc("reload3.stop", 1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle("reload3.idle", 2, 1'b0, 1'b0);

    // Reload value 1 gives done every cycle.
    cyc("reload1", 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle("reload1", 1, 1'b1, 1'b1);
    cyc("reload1.stop", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
`endif

    // Stop at 4 (with pause also high): back to IDLE, count kept, no done.
    cyc("stop", 1'b1, 10, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0);
    for (int j = 1; j <= 6; j++) idle("stop", 10 - j, 1'b1, 1'b0);
    cyc("stop.req", 1'b0, 0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) idle("stop.after", 4, 1'b0, 1'b0);

`ifndef COUNTER_DOWN_RELOAD_EN
    // Start without load counts down from the retained count.
    cyc("resume", 1'b0, 0, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    for (int j = 1; j <= 4; j++) idle("resume", 4 - j, j < 4, j == 4);
`endif

    // Zero-length timers: effective count 0 goes straight to DONE, never busy.
    cyc("zero.load7", 1'b1, 7, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0);
    cyc("zero.ldst", 1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle("zero.ldst.end", 0, 1'b0, 1'b0);
    cyc("zero.start", 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle("zero.start.end", 0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
